// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and march element tables for the MBIST sequencer.
//   state_t : controller states
//   op_t    : memory operation (read/write of background "0" or "1")
//   dir_t   : address direction of a march element
//   Table functions give, for a mode (0 = MATS+, 1 = March C-) and element,
//   the last element index, the last op index, the direction and each op.
package mbist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {RD0, RD1, WR0, WR1} op_t;
   typedef enum logic {UP, DOWN} dir_t;

   localparam int unsigned ELEM_W = 3;  // up to 6 elements
   localparam int unsigned OPIX_W = 1;  // up to 2 ops per element

   typedef logic [ELEM_W-1:0] elem_t;
   typedef logic [OPIX_W-1:0] opix_t;

   function automatic elem_t last_elem(input logic mode);
      return mode ? elem_t'(5) : elem_t'(2);
   endfunction

   // Single-op elements: the leading w0 of both algorithms and the trailing
   // r0 of March C-; every other element is a read followed by a write.
   function automatic opix_t elem_last_op(input logic mode, input elem_t e);
      if (e == elem_t'(0) || (mode && e == elem_t'(5))) return opix_t'(0);
      return opix_t'(1);
   endfunction

   function automatic dir_t elem_dir(input logic mode, input elem_t e);
      if (!mode) return (e == elem_t'(2)) ? DOWN : UP;
      return (e == elem_t'(3) || e == elem_t'(4)) ? DOWN : UP;
   endfunction

   function automatic op_t elem_op(input logic mode, input elem_t e, input opix_t ix);
      op_t op;
      case ({mode, e, ix})
         {1'b0, 3'd0, 1'b0}: op = WR0;
         {1'b0, 3'd1, 1'b0}: op = RD0;
         {1'b0, 3'd1, 1'b1}: op = WR1;
         {1'b0, 3'd2, 1'b0}: op = RD1;
         {1'b0, 3'd2, 1'b1}: op = WR0;
         {1'b1, 3'd0, 1'b0}: op = WR0;
         {1'b1, 3'd1, 1'b0}: op = RD0;
         {1'b1, 3'd1, 1'b1}: op = WR1;
         {1'b1, 3'd2, 1'b0}: op = RD1;
         {1'b1, 3'd2, 1'b1}: op = WR0;
         {1'b1, 3'd3, 1'b0}: op = RD0;
         {1'b1, 3'd3, 1'b1}: op = WR1;
         {1'b1, 3'd4, 1'b0}: op = RD1;
         {1'b1, 3'd4, 1'b1}: op = WR0;
         {1'b1, 3'd5, 1'b0}: op = RD0;
         default:            op = RD0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mbist_resp_chk.sv
// mbist_resp_chk: read-response checker for the MBIST sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : clears fail status (accepted start)
//   flush           : drops all in-flight compares (abort)
//   push_vld/exp/addr : a read issued this cycle with its expected data/address
//   rdata           : memory read data, valid RD_LAT cycles after the read
//   fail, fail_addr, fail_count : sticky flag, first failing address,
//                     saturating mismatch count
module mbist_resp_chk #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              flush,
   input  logic              push_vld,
   input  logic [DATA_W-1:0] push_exp,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] rdata,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [CNT_W-1:0]  fail_count
);

   logic [RD_LAT-1:0]             vld_q, vld_d;
   logic [RD_LAT-1:0][DATA_W-1:0] exp_q, exp_d;
   logic [RD_LAT-1:0][ADDR_W-1:0] adr_q, adr_d;
   logic                          fail_q, fail_d;
   logic [ADDR_W-1:0]             fail_addr_q, fail_addr_d;
   logic [CNT_W-1:0]              fail_count_q, fail_count_d;
   logic                          mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q        <= '0;
         exp_q        <= '0;
         adr_q        <= '0;
         fail_q       <= 1'b0;
         fail_addr_q  <= '0;
         fail_count_q <= '0;
      end else begin
         vld_q        <= vld_d;
         exp_q        <= exp_d;
         adr_q        <= adr_d;
         fail_q       <= fail_d;
         fail_addr_q  <= fail_addr_d;
         fail_count_q <= fail_count_d;
      end
   end

   always_comb begin
      // Whole-vector shifts keep RD_LAT == 1 legal: stage 0 is the oldest
      // entry shifted out and replaced by this cycle's read.
      vld_d    = vld_q << 1;
      exp_d    = exp_q << DATA_W;
      adr_d    = adr_q << ADDR_W;
      vld_d[0] = push_vld;
      exp_d[0] = push_exp;
      adr_d[0] = push_addr;
      if (flush) vld_d = '0;

      mismatch     = vld_q[RD_LAT-1] && (exp_q[RD_LAT-1] != rdata);
      fail_d       = fail_q;
      fail_addr_d  = fail_addr_q;
      fail_count_d = fail_count_q;
      if (clear) begin
         fail_d       = 1'b0;
         fail_addr_d  = '0;
         fail_count_d = '0;
      end else if (mismatch) begin
         fail_d = 1'b1;
         if (!fail_q) fail_addr_d = adr_q[RD_LAT-1];
         if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
      end
   end

   assign fail       = fail_q;
   assign fail_addr  = fail_addr_q;
   assign fail_count = fail_count_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: MBIST sequencer running MATS+ (mode 0) or March C-
// (mode 1) over a 2^ADDR_W x DATA_W memory, one op per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : begin test (IDLE/DONE only), abort to IDLE (RUN/DRAIN)
//   mode, bg      : algorithm select and data background, latched on start
//   test_en, busy : high in RUN/DRAIN;  done : high in DONE
//   mem_*         : memory test port; mem_rdata valid RD_LAT after mem_re
//   fail, fail_addr, fail_count : result status
module mbist_march_ctrl import mbist_pkg::*; #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [DATA_W-1:0] bg,
   output logic              test_en,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [CNT_W-1:0]  fail_count
);

   localparam int unsigned DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [DATA_W-1:0]  bg_q, bg_d;
   elem_t              elem_q, elem_d;
   opix_t              opix_q, opix_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;

   op_t                cur_op;
   dir_t               cur_dir;
   elem_t              nxt_elem;
   logic               op_last, addr_last, elem_last;
   logic               start_acc, flush;
   logic               push_vld;
   logic [DATA_W-1:0]  push_exp;

   assign cur_op    = elem_op(mode_q, elem_q, opix_q);
   assign cur_dir   = elem_dir(mode_q, elem_q);
   assign nxt_elem  = elem_q + 1'b1;
   assign op_last   = (opix_q == elem_last_op(mode_q, elem_q));
   assign addr_last = (cur_dir == UP) ? (addr_q == '1) : (addr_q == '0);
   assign elem_last = (elem_q == last_elem(mode_q));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         bg_q    <= '0;
         elem_q  <= '0;
         opix_q  <= '0;
         addr_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         bg_q    <= bg_d;
         elem_q  <= elem_d;
         opix_q  <= opix_d;
         addr_q  <= addr_d;
         drain_q <= drain_d;
      end
   end

   // Next state: op index steps first, then address, then element, so all
   // ops at one address complete before the address moves.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      bg_d      = bg_q;
      elem_d    = elem_q;
      opix_d    = opix_q;
      addr_d    = addr_q;
      drain_d   = drain_q;
      start_acc = 1'b0;
      flush     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = RUN;
               mode_d    = mode;
               bg_d      = bg;
               elem_d    = '0;
               opix_d    = '0;
               addr_d    = '0;  // element 0 is ascending in both algorithms
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (!op_last) begin
               opix_d = opix_q + 1'b1;
            end else begin
               opix_d = '0;
               if (!addr_last) begin
                  addr_d = (cur_dir == UP) ? addr_q + 1'b1 : addr_q - 1'b1;
               end else if (!elem_last) begin
                  elem_d = nxt_elem;
                  addr_d = (elem_dir(mode_q, nxt_elem) == UP) ? '0 : '1;
               end else begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (drain_q == DRAIN_W'(RD_LAT - 1)) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      test_en   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      push_vld  = 1'b0;
      push_exp  = '0;
      unique case (state_q)
         RUN: begin
            test_en  = 1'b1;
            busy     = 1'b1;
            mem_addr = addr_q;
            unique case (cur_op)
               RD0: begin mem_re = 1'b1; push_vld = 1'b1; push_exp = bg_q;  end
               RD1: begin mem_re = 1'b1; push_vld = 1'b1; push_exp = ~bg_q; end
               WR0: begin mem_we = 1'b1; mem_wdata = bg_q;  end
               WR1: begin mem_we = 1'b1; mem_wdata = ~bg_q; end
               default: ;
            endcase
         end
         DRAIN: begin
            test_en = 1'b1;
            busy    = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   mbist_resp_chk #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT),
      .CNT_W  (CNT_W)
   ) u_resp_chk (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_acc),
      .flush      (flush),
      .push_vld   (push_vld),
      .push_exp   (push_exp),
      .push_addr  (addr_q),
      .rdata      (mem_rdata),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_count (fail_count)
   );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: two instances (RD_LAT=1/CNT_W=8 and
// RD_LAT=3/CNT_W=2) on a 4-word memory model with injectable faults.
// Expected op traces and end-of-test results are queued when a test is
// launched; negedge monitors pop and compare as the DUTs produce them.
module tb_mbist_march_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // ---------------- instance A: RD_LAT=1, CNT_W=8 ----------------
   logic       start_a = 1'b0, abort_a = 1'b0, mode_a = 1'b0;
   logic [7:0] bg_a = 8'h00;
   logic       test_en_a, busy_a, done_a, we_a, re_a, fail_a;
   logic [1:0] addr_a, fail_addr_a;
   logic [7:0] wdata_a, rdata_a, fail_count_a;

   mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a), .bg(bg_a),
      .test_en(test_en_a), .busy(busy_a), .done(done_a),
      .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .mem_re(re_a), .mem_rdata(rdata_a),
      .fail(fail_a), .fail_addr(fail_addr_a), .fail_count(fail_count_a));

   // ---------------- instance B: RD_LAT=3, CNT_W=2 ----------------
   logic       start_b = 1'b0, abort_b = 1'b0, mode_b = 1'b0;
   logic [7:0] bg_b = 8'h00;
   logic       test_en_b, busy_b, done_b, we_b, re_b, fail_b;
   logic [1:0] addr_b, fail_addr_b, fail_count_b;
   logic [7:0] wdata_b, rdata_b;

   mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(3), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b), .bg(bg_b),
      .test_en(test_en_b), .busy(busy_b), .done(done_b),
      .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .mem_re(re_b), .mem_rdata(rdata_b),
      .fail(fail_b), .fail_addr(fail_addr_b), .fail_count(fail_count_b));

   // ---------------- memory models with fault injection ----------------
   logic [7:0] mem_a [4];
   logic [7:0] mem_b [4];
   logic [7:0] pipe_a;
   logic [7:0] pipe_b [3];
   logic [1:0] fa_addr_a = 2'd0, fa_addr_b = 2'd0;
   logic [7:0] sa1_a = 8'h00, sa0_a = 8'h00, inv_a = 8'h00;
   logic [7:0] sa1_b = 8'h00, sa0_b = 8'h00, inv_b = 8'h00;

   function automatic logic [7:0] faulty(input logic [7:0] d, input logic hit,
                                         input logic [7:0] s1, input logic [7:0] s0,
                                         input logic [7:0] inv);
      logic [7:0] v;
      v = hit ? ((d & ~s0) | s1) : d;
      return v ^ inv;
   endfunction

   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      pipe_a <= faulty(mem_a[addr_a], addr_a == fa_addr_a, sa1_a, sa0_a, inv_a);
      if (we_b) mem_b[addr_b] <= wdata_b;
      pipe_b[0] <= faulty(mem_b[addr_b], addr_b == fa_addr_b, sa1_b, sa0_b, inv_b);
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign rdata_a = pipe_a;
   assign rdata_b = pipe_b[2];

   // ---------------- scoreboard ----------------
   typedef struct {
      logic       we;
      logic [1:0] addr;
      logic [7:0] wdata;
   } op_exp_t;

   typedef struct {
      int         lat;
      logic       fail;
      logic [1:0] faddr;
      int         cnt;
   } res_exp_t;

   op_exp_t  qa[$], qb[$];
   res_exp_t ra[$], rb[$];
   int       c0_a = 0, c0_b = 0;
   logic     dprev[2] = '{1'b0, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected op trace from a hand-written element list: direction letters
   // plus op pairs ("r0w1" = read 0, write 1).
   task automatic push_march(input bit inst, input bit m, input logic [7:0] b);
      string   dirs;
      string   ops [6];
      op_exp_t e;
      byte     c;
      int      a;
      if (!m) begin
         dirs = "UUD";
         ops[0] = "w0"; ops[1] = "r0w1"; ops[2] = "r1w0";
      end else begin
         dirs = "UUUDDU";
         ops[0] = "w0"; ops[1] = "r0w1"; ops[2] = "r1w0";
         ops[3] = "r0w1"; ops[4] = "r1w0"; ops[5] = "r0";
      end
      for (int el = 0; el < dirs.len(); el++) begin
         for (int k = 0; k < 4; k++) begin
            c = dirs[el];
            a = (c == "D") ? 3 - k : k;
            for (int j = 0; j < ops[el].len(); j += 2) begin
               c       = ops[el][j];
               e.we    = (c == "w");
               e.addr  = a[1:0];
               c       = ops[el][j+1];
               e.wdata = e.we ? ((c == "1") ? ~b : b) : 8'h00;
               if (inst) qb.push_back(e); else qa.push_back(e);
            end
         end
      end
   endtask

   task automatic push_res(input bit inst, input int lat, input logic f,
                           input logic [1:0] fa, input int cnt);
      res_exp_t r;
      r.lat = lat; r.fail = f; r.faddr = fa; r.cnt = cnt;
      if (inst) rb.push_back(r); else ra.push_back(r);
   endtask

   task automatic mon_step(input bit inst, input logic we, input logic re, input logic busy,
                           input logic done, input logic [1:0] addr, input logic [7:0] wd,
                           input logic fl, input logic [1:0] fad, input logic [7:0] cnt);
      op_exp_t  e;
      res_exp_t r;
      string    p;
      int       n;
      p = inst ? "b" : "a";
      if (!busy) chk({p, "_idle_bus"}, {20'd0, we, re, addr, wd}, 32'd0);
      if (we || re) begin
         n = inst ? qb.size() : qa.size();
         if (n == 0) chk({p, "_extra_op"}, {20'd0, we, re, addr, wd}, 32'd0);
         else begin
            if (inst) e = qb.pop_front(); else e = qa.pop_front();
            chk({p, "_we"}, {31'd0, we}, {31'd0, e.we});
            chk({p, "_re"}, {31'd0, re}, {31'd0, !e.we});
            chk({p, "_addr"}, {30'd0, addr}, {30'd0, e.addr});
            chk({p, "_wdata"}, {24'd0, wd}, {24'd0, e.wdata});
         end
      end
      if (done && !dprev[inst]) begin
         n = inst ? rb.size() : ra.size();
         if (n == 0) chk({p, "_extra_done"}, {31'd0, done}, 32'd0);
         else begin
            if (inst) r = rb.pop_front(); else r = ra.pop_front();
            chk({p, "_done_latency"}, cyc - (inst ? c0_b : c0_a) + 1, r.lat);
            chk({p, "_fail"}, {31'd0, fl}, {31'd0, r.fail});
            chk({p, "_fail_addr"}, {30'd0, fad}, {30'd0, r.faddr});
            chk({p, "_fail_count"}, {24'd0, cnt}, r.cnt);
         end
      end
      dprev[inst] = done;
   endtask

   always @(negedge clk)
      if (!rst) mon_step(1'b0, we_a, re_a, busy_a, done_a, addr_a, wdata_a,
                         fail_a, fail_addr_a, fail_count_a);

   always @(negedge clk)
      if (!rst) mon_step(1'b1, we_b, re_b, busy_b, done_b, addr_b, wdata_b,
                         fail_b, fail_addr_b, {6'd0, fail_count_b});

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input bit inst, input bit m, input logic [7:0] b);
      @(posedge clk); #1;
      if (inst) begin start_b = 1'b1; mode_b = m; bg_b = b; end
      else      begin start_a = 1'b1; mode_a = m; bg_a = b; end
      @(posedge clk); #1;
      if (inst) begin start_b = 1'b0; c0_b = cyc; end
      else      begin start_a = 1'b0; c0_a = cyc; end
   endtask

   task automatic wait_done(input bit inst, input int max);
      logic d;
      for (int i = 0; i < max; i++) begin
         d = inst ? done_b : done_a;
         if (d) break;
         @(posedge clk); #1;
      end
      d = inst ? done_b : done_a;
      if (!d) chk(inst ? "b_done_timeout" : "a_done_timeout", {31'd0, d}, 32'd1);
   endtask

   task automatic run(input bit inst, input bit m, input logic [7:0] b, input int lat,
                      input logic f, input logic [1:0] fa, input int cnt);
      push_march(inst, m, b);
      push_res(inst, lat, f, fa, cnt);
      do_start(inst, m, b);
      wait_done(inst, 100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      for (int i = 0; i < 4; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
      pipe_a = 8'h00;
      for (int i = 0; i < 3; i++) pipe_b[i] = 8'h00;

      // Reset state, and reset dominating a simultaneous start
      repeat (2) @(posedge clk);
      #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      chk("a_rst_flags", {26'd0, test_en_a, busy_a, done_a, we_a, re_a, fail_a}, 32'd0);
      chk("a_rst_bus", {14'd0, addr_a, wdata_a, fail_addr_a, fail_count_a}, 32'd0);
      chk("b_rst_flags", {26'd0, test_en_b, busy_b, done_b, we_b, re_b, fail_b}, 32'd0);
      chk("b_rst_bus", {18'd0, addr_b, wdata_b, fail_addr_b, fail_count_b}, 32'd0);
      start_a = 1'b0;
      rst = 1'b0;

      // MATS+, bg 00, fault-free: 20 ops, done on cycle 22
      run(1'b0, 1'b0, 8'h00, 22, 1'b0, 2'd0, 0);

      // abort in DONE has no effect
      @(posedge clk); #1; abort_a = 1'b1;
      @(posedge clk); #1; abort_a = 1'b0;
      chk("a_abort_in_done", {31'd0, done_a}, 32'd1);

      // March C-, bg A5, fault-free: 40 ops, down elements 3..0
      run(1'b0, 1'b1, 8'hA5, 42, 1'b0, 2'd0, 0);

      // March C-, addr 2 bit 0 stuck-at-1: r0 fails in elements 1, 3, 5
      sa1_a = 8'h01; fa_addr_a = 2'd2;
      run(1'b0, 1'b1, 8'h00, 42, 1'b1, 2'd2, 3);

      // start in DONE clears fail; start during RUN is ignored
      sa1_a = 8'h00;
      push_march(1'b0, 1'b0, 8'h00);
      push_res(1'b0, 22, 1'b0, 2'd0, 0);
      do_start(1'b0, 1'b0, 8'h00);
      chk("a_start_clears_fail", {21'd0, fail_a, fail_addr_a, fail_count_a}, 32'd0);
      repeat (4) @(posedge clk);
      #1; start_a = 1'b1; mode_a = 1'b1; bg_a = 8'hFF;
      @(posedge clk); #1; start_a = 1'b0;
      wait_done(1'b0, 100);

      // abort mid-RUN after the first mismatch: IDLE next cycle, fail kept
      sa1_a = 8'h01; fa_addr_a = 2'd2;
      push_march(1'b0, 1'b1, 8'h00);
      do_start(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 40; i++) begin
         if (fail_a) break;
         @(posedge clk); #1;
      end
      chk("a_fail_before_abort", {31'd0, fail_a}, 32'd1);
      abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      qa.delete();
      chk("a_abort_strobes", {27'd0, busy_a, test_en_a, we_a, re_a, done_a}, 32'd0);
      chk("a_abort_keeps_fail", {21'd0, fail_a, fail_addr_a, fail_count_a}, {21'd0, 1'b1, 2'd2, 8'd1});
      @(posedge clk); #1;
      chk("a_abort_stays_idle", {29'd0, busy_a, we_a, re_a}, 32'd0);

      // rst mid-RUN: IDLE next cycle, fail cleared
      push_march(1'b0, 1'b1, 8'h00);
      do_start(1'b0, 1'b1, 8'h00);
      repeat (15) @(posedge clk);
      #1;
      chk("a_fail_before_rst", {31'd0, fail_a}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      qa.delete();
      chk("a_rst_midrun_flags", {26'd0, busy_a, test_en_a, we_a, re_a, done_a, fail_a}, 32'd0);
      chk("a_rst_midrun_status", {22'd0, fail_addr_a, fail_count_a}, 32'd0);
      sa1_a = 8'h00;

      // RD_LAT=3, MATS+, addr 0 bit 0 stuck-at-0: only the last read fails;
      // fail must be visible when done rises, DRAIN is 3 cycles (done on 24)
      sa0_b = 8'h01; fa_addr_b = 2'd0;
      run(1'b1, 1'b0, 8'h00, 24, 1'b1, 2'd0, 1);

      // CNT_W=2, every read inverted: 8 mismatches saturate at 3, first addr 0
      sa0_b = 8'h00; inv_b = 8'hFF;
      run(1'b1, 1'b0, 8'h3C, 24, 1'b1, 2'd0, 3);

      repeat (3) @(posedge clk);
      #1;
      chk("a_ops_left", qa.size(), 32'd0);
      chk("b_ops_left", qb.size(), 32'd0);
      chk("a_results_left", ra.size(), 32'd0);
      chk("b_results_left", rb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
